handshake_cmd_copy_master: RTL and testbench

Initiator-side engine for the A/B command handshake. It drives AVALID/AADDR/AWMSK/ADATA and consumes BVALID/BDATA, i.e. it sits on the opposite end from handshake_cmd_sram.
On a start pulse it copies LEN consecutive 32-bit words from a source address to a destination address, one outstanding command at a time.
It is used in benches and SoC glue as a DMA-style bus master that runs alongside, or instead of, the ncpu32k dbus.

---
 rtl/handshake_cmd_copy_master_pkg.sv | 21 ++
 rtl/handshake_cmd_copy_master.sv | 147 ++++++++++++++
 tb/tb_handshake_cmd_copy_master.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/handshake_cmd_copy_master_pkg.sv
// Shared widths, exception codes and FSM encoding for the A/B command copy master.
package handshake_cmd_copy_master_pkg;

    localparam int NCPU_AW   = 32;
    localparam int NCPU_DW   = 32;
    localparam int CPY_LEN_W = 16;

    localparam logic [1:0] EXC_NONE = 2'b00;

    localparam logic [NCPU_DW/8-1:0] WMSK_FULL = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_FIN
    } state_t;

endpackage

// File: rtl/handshake_cmd_copy_master.sv
// DMA-style initiator: copies len words from src_addr to dst_addr over the A/B
// command handshake, one outstanding command at a time.
module handshake_cmd_copy_master
    import handshake_cmd_copy_master_pkg::*;
#(
    parameter int AW    = NCPU_AW,
    parameter int DW    = NCPU_DW,
    parameter int LEN_W = CPY_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     src_addr,
    input  logic [AW-1:0]     dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_exc,
    output logic              AVALID,
    input  logic              AREADY,
    output logic [AW-1:0]     AADDR,
    output logic [DW/8-1:0]   AWMSK,
    output logic [DW-1:0]     ADATA,
    output logic [1:0]        AEXC,
    input  logic              BVALID,
    output logic              BREADY,
    input  logic [DW-1:0]     BDATA,
    input  logic [1:0]        BEXC
);

    state_t            r_state;
    state_t            w_next;
    logic [AW-1:0]     r_src;
    logic [AW-1:0]     r_dst;
    logic [LEN_W-1:0]  r_rem;
    logic [DW-1:0]     r_data;
    logic              r_err;
    logic [1:0]        r_err_exc;
    logic              w_in_resp;
    logic              w_bexc_err;

    assign w_in_resp  = (r_state == ST_RD_RESP) || (r_state == ST_WR_RESP);
    assign w_bexc_err = (BEXC != EXC_NONE);

    assign busy    = (r_state != ST_IDLE);
    assign err     = r_err;
    assign err_exc = r_err_exc;
    assign AEXC    = EXC_NONE;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and A/B channel outputs, decoded purely from state so the
    // A-channel stays stable until the handshake completes
    always_comb begin
        w_next = r_state;
        AVALID = 1'b0;
        AADDR  = '0;
        AWMSK  = '0;
        ADATA  = '0;
        BREADY = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (len == '0) ? ST_FIN : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                AVALID = 1'b1;
                AADDR  = r_src;
                if (AREADY) begin
                    w_next = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    w_next = w_bexc_err ? ST_FIN : ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                AVALID = 1'b1;
                AADDR  = r_dst;
                AWMSK  = '1;
                ADATA  = r_data;
                if (AREADY) begin
                    w_next = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    if (w_bexc_err || (r_rem == LEN_W'(1))) begin
                        w_next = ST_FIN;
                    end else begin
                        w_next = ST_RD_REQ;
                    end
                end
            end
            ST_FIN: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Copy parameters, pointers, word counter, read data and sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_src     <= '0;
            r_dst     <= '0;
            r_rem     <= '0;
            r_data    <= '0;
            r_err     <= 1'b0;
            r_err_exc <= EXC_NONE;
        end else if (r_state == ST_IDLE) begin
            if (start) begin
                r_src     <= {src_addr[AW-1:2], 2'b00};
                r_dst     <= {dst_addr[AW-1:2], 2'b00};
                r_rem     <= len;
                r_err     <= 1'b0;
                r_err_exc <= EXC_NONE;
            end
        end else if (w_in_resp && BVALID) begin
            if (w_bexc_err) begin
                r_err     <= 1'b1;
                r_err_exc <= BEXC;
            end else if (r_state == ST_RD_RESP) begin
                r_data <= BDATA;
            end else begin
                r_src <= r_src + AW'(4);
                r_dst <= r_dst + AW'(4);
                r_rem <= r_rem - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_handshake_cmd_copy_master.sv
// Scoreboard bench: expected A-channel commands and completion status are queued
// by the stimulus; a posedge monitor pops and compares on each handshake/done.
module tb_handshake_cmd_copy_master;
    import handshake_cmd_copy_master_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LEN_W = 16;
    localparam int DELAY = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [AW-1:0]     src_addr = '0;
    logic [AW-1:0]     dst_addr = '0;
    logic [LEN_W-1:0]  len = '0;
    logic              busy, done, err;
    logic [1:0]        err_exc;
    logic              AVALID;
    logic              AREADY = 1'b0;
    logic [AW-1:0]     AADDR;
    logic [DW/8-1:0]   AWMSK;
    logic [DW-1:0]     ADATA;
    logic [1:0]        AEXC;
    logic              BVALID = 1'b0;
    logic              BREADY;
    logic [DW-1:0]     BDATA = '0;
    logic [1:0]        BEXC = 2'b00;

    handshake_cmd_copy_master #(.AW(AW), .DW(DW), .LEN_W(LEN_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .err(err), .err_exc(err_exc),
        .AVALID(AVALID), .AREADY(AREADY), .AADDR(AADDR), .AWMSK(AWMSK),
        .ADATA(ADATA), .AEXC(AEXC), .BVALID(BVALID), .BREADY(BREADY),
        .BDATA(BDATA), .BEXC(BEXC)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [DW/8-1:0] wmsk;
        logic [DW-1:0]   data;
    } cmd_t;

    typedef struct {
        logic       err;
        logic [1:0] exc;
    } fin_t;

    cmd_t exp_cmd[$];
    fin_t exp_fin[$];
    int   checks = 0;
    int   failures = 0;
    int   hs_count = 0;
    int   held_count = 0;
    logic [31:0] mem [logic [31:0]];

    // responder state
    int              stall_cfg = 0;
    bit              hold_wr = 1'b0;
    int              err_read = 0;
    int              rd_count = 0;
    bit              pend = 1'b0;
    int              dly = 0;
    logic [DW-1:0]   pend_data = '0;
    logic [1:0]      pend_exc = 2'b00;
    bit              a_fire = 1'b0;
    bit              b_fire = 1'b0;
    cmd_t            fire_cmd;
    logic            rst_q = 1'b0;

    always @(posedge clk) rst_q <= rst_n;

    // Memory responder: decides AREADY/BVALID at each negedge, reset with the DUT
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_q) begin
                AREADY = 1'b0; BVALID = 1'b0; BEXC = 2'b00;
                pend = 1'b0; a_fire = 1'b0; b_fire = 1'b0;
            end else begin
                if (b_fire) begin
                    BVALID = 1'b0;
                    BEXC   = 2'b00;
                end
                if (a_fire) begin
                    pend = 1'b1; dly = DELAY; pend_exc = 2'b00; pend_data = '0;
                    if (fire_cmd.wmsk != '0) begin
                        mem[fire_cmd.addr] = fire_cmd.data;
                    end else begin
                        rd_count++;
                        if (rd_count == err_read) pend_exc = 2'b01;
                        else if (mem.exists(fire_cmd.addr)) pend_data = mem[fire_cmd.addr];
                    end
                end
                if (pend) begin
                    if (dly <= 1) begin
                        BVALID = 1'b1; BDATA = pend_data; BEXC = pend_exc; pend = 1'b0;
                    end else begin
                        dly--;
                    end
                end
                AREADY = 1'b0;
                if (AVALID && !pend && !BVALID) begin
                    if (AWMSK != '0 && hold_wr) AREADY = 1'b0;
                    else if (stall_cfg > 0) stall_cfg--;
                    else AREADY = 1'b1;
                end
                a_fire = AVALID && AREADY;
                fire_cmd.addr = AADDR; fire_cmd.wmsk = AWMSK; fire_cmd.data = ADATA;
                b_fire = BVALID && BREADY;
            end
        end
    end

    // Monitor: A-channel stability, command scoreboard and completion scoreboard
    logic            held = 1'b0;
    cmd_t            h_cmd;
    always @(posedge clk) begin
        cmd_t e;
        fin_t f;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checks++;
                if (!AVALID || AADDR != h_cmd.addr || AWMSK != h_cmd.wmsk || ADATA != h_cmd.data) begin
                    failures++;
                    $display("FAIL a_stable actual v=%0b a=%h m=%h d=%h required v=1 a=%h m=%h d=%h",
                             AVALID, AADDR, AWMSK, ADATA, h_cmd.addr, h_cmd.wmsk, h_cmd.data);
                end
            end
            held = AVALID && !AREADY;
            if (held) held_count++;
            h_cmd.addr = AADDR; h_cmd.wmsk = AWMSK; h_cmd.data = ADATA;
            if (AVALID && AREADY) begin
                hs_count++;
                checks++;
                if (exp_cmd.size() == 0) begin
                    failures++;
                    $display("FAIL a_cmd unexpected actual a=%h m=%h d=%h required none", AADDR, AWMSK, ADATA);
                end else begin
                    e = exp_cmd.pop_front();
                    if (AADDR != e.addr || AWMSK != e.wmsk || AEXC != 2'b00 ||
                        (e.wmsk != '0 && ADATA != e.data)) begin
                        failures++;
                        $display("FAIL a_cmd actual a=%h m=%h d=%h x=%b required a=%h m=%h d=%h x=00",
                                 AADDR, AWMSK, ADATA, AEXC, e.addr, e.wmsk, e.data);
                    end
                end
            end
            if (done) begin
                checks++;
                if (exp_fin.size() == 0) begin
                    failures++;
                    $display("FAIL done unexpected actual err=%b exc=%b required no done", err, err_exc);
                end else begin
                    f = exp_fin.pop_front();
                    if (err != f.err || err_exc != f.exc) begin
                        failures++;
                        $display("FAIL done_status actual err=%b exc=%b required err=%b exc=%b",
                                 err, err_exc, f.err, f.exc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n, input int fail_rd);
        cmd_t c;
        fin_t f;
        for (int i = 0; i < n; i++) begin
            c.addr = s + 32'(4 * i); c.wmsk = '0; c.data = '0;
            exp_cmd.push_back(c);
            if (fail_rd == i + 1) break;
            c.addr = d + 32'(4 * i); c.wmsk = WMSK_FULL; c.data = mem[s + 32'(4 * i)];
            exp_cmd.push_back(c);
        end
        f.err = (fail_rd > 0 && fail_rd <= n);
        f.exc = f.err ? 2'b01 : 2'b00;
        exp_fin.push_back(f);
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int n);
        @(negedge clk);
        src_addr = s; dst_addr = d; len = LEN_W'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (!busy) return;
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL %s timeout actual busy=1 required busy=0 within %0d cycles", name, bound);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int held0;
        int i;
        for (int k = 0; k < 4; k++) begin
            mem[32'h100 + 32'(4 * k)] = 32'hA0A0_0000 + 32'(k);
            mem[32'h400 + 32'(4 * k)] = 32'hB0B0_0000 + 32'(k);
        end
        mem[32'h504] = 32'hDEAD_BEEF;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
        chk("rst_err_exc", err_exc, 0); chk("rst_avalid", AVALID, 0); chk("rst_bready", BREADY, 0);
        chk("rst_awmsk", AWMSK, 0); chk("rst_aaddr", AADDR, 0); chk("rst_adata", ADATA, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // basic 4-word copy; low address bits must be ignored
        hs0 = hs_count;
        push_copy(32'h100, 32'h200, 4, 0);
        pulse_start(32'h103, 32'h202, 4);
        wait_idle("copy4", 200);
        for (int k = 0; k < 4; k++) chk("copy4_mem", mem[32'h200 + 32'(4 * k)], 32'hA0A0_0000 + 32'(k));
        chk("copy4_hs", 64'(hs_count - hs0), 8);
        chk("copy4_err", err, 0);

        // len=0: FIN directly, one-cycle busy, no command
        hs0 = hs_count;
        push_copy(32'h100, 32'h200, 0, 0);
        @(negedge clk);
        src_addr = 32'h100; dst_addr = 32'h200; len = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("len0_busy", busy, 1); chk("len0_done", done, 1); chk("len0_avalid", AVALID, 0);
        @(negedge clk);
        chk("len0_busy_end", busy, 0); chk("len0_done_end", done, 0);
        chk("len0_hs", 64'(hs_count - hs0), 0);

        // AREADY held low for 5 cycles on the first command
        held0 = held_count;
        stall_cfg = 5;
        push_copy(32'h100, 32'h300, 4, 0);
        pulse_start(32'h100, 32'h300, 4);
        wait_idle("stall", 300);
        chk("stall_held", 64'(held_count - held0), 5);
        for (int k = 0; k < 4; k++) chk("stall_mem", mem[32'h300 + 32'(4 * k)], 32'hA0A0_0000 + 32'(k));

        // error on the 2nd read
        rd_count = 0; err_read = 2;
        push_copy(32'h400, 32'h500, 4, 2);
        pulse_start(32'h400, 32'h500, 4);
        wait_idle("err", 200);
        err_read = 0;
        chk("err_flag", err, 1); chk("err_exc", err_exc, 2'b01); chk("err_busy", busy, 0);
        chk("err_mem0", mem[32'h500], 32'hB0B0_0000);
        chk("err_mem1", mem[32'h504], 32'hDEAD_BEEF);

        // start mid-copy is ignored; err cleared by accepted start
        push_copy(32'h100, 32'h600, 4, 0);
        pulse_start(32'h100, 32'h600, 4);
        chk("restart_err_clr", err, 0); chk("restart_exc_clr", err_exc, 0);
        repeat (3) @(negedge clk);
        src_addr = 32'h400; dst_addr = 32'h800; len = LEN_W'(1); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("midstart", 200);
        for (int k = 0; k < 4; k++) chk("midstart_mem", mem[32'h600 + 32'(4 * k)], 32'hA0A0_0000 + 32'(k));
        chk("midstart_no_800", 64'(mem.exists(32'h800)), 0);

        // reset during WR_REQ
        hold_wr = 1'b1;
        push_copy(32'h100, 32'h700, 1, 1);
        void'(exp_fin.pop_back());
        pulse_start(32'h100, 32'h700, 2);
        i = 0;
        while (!(AVALID && AWMSK != '0) && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("rst_mid_reach_wr", 64'(i < 50), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hold_wr = 1'b0;
        chk("rst_mid_avalid", AVALID, 0); chk("rst_mid_bready", BREADY, 0);
        chk("rst_mid_busy", busy, 0); chk("rst_mid_done", done, 0);
        repeat (2) @(negedge clk);
        chk("rst_mid_no_write", 64'(mem.exists(32'h700)), 0);
        push_copy(32'h100, 32'h700, 2, 0);
        pulse_start(32'h100, 32'h700, 2);
        wait_idle("post_rst", 200);
        chk("post_rst_mem0", mem[32'h700], 32'hA0A0_0000);
        chk("post_rst_mem1", mem[32'h704], 32'hA0A0_0001);

        repeat (3) @(negedge clk);
        chk("cmd_queue_empty", 64'(exp_cmd.size()), 0);
        chk("fin_queue_empty", 64'(exp_fin.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
